// File: rtl/pc_gen_bp.sv
// Fetch-PC generator with a direct-mapped BTB (2-bit counters) for next-line prediction.
// Next-PC priority: bubble, EX redirect, stall, BTB prediction, sequential PC+4.
module pc_gen_bp #(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  RESET_PC    = 32'h8000_0000,
    parameter int unsigned      BTB_ENTRIES = 16,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             F_stall_i,
    input  logic             F_bubble_i,
    input  logic             ex_valid_i,
    input  logic [1:0]       ex_kind_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic             ex_taken_i,
    input  logic [XLEN-1:0]  ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [XLEN-1:0]  ex_pred_target_i,
    output logic [XLEN-1:0]  F_pc_o,
    output logic             f_pred_taken_o,
    output logic [XLEN-1:0]  f_pred_target_o,
    output logic             redirect_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;

    localparam logic [1:0] KIND_BRANCH = 2'b00;
    localparam logic [1:0] KIND_RSVD   = 2'b11;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_ENTRIES-1:0] btb_jump;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]   f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             ctl, act_taken, is_jump;
    logic [XLEN-1:0]  act_tgt, correct_pc, next_pc;

    always_comb begin
        f_idx           = F_pc_o[IDX+1:2];
        f_tag           = F_pc_o[XLEN-1:IDX+2];
        f_hit           = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
        f_pred_taken_o  = f_hit && (btb_jump[f_idx] || btb_ctr[f_idx][1]);
        f_pred_target_o = f_pred_taken_o ? btb_target[f_idx] : '0;
    end

    always_comb begin
        e_idx      = ex_pc_i[IDX+1:2];
        e_tag      = ex_pc_i[XLEN-1:IDX+2];
        e_hit      = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);
        ctl        = ex_valid_i && (ex_kind_i != KIND_RSVD);
        is_jump    = (ex_kind_i != KIND_BRANCH);
        act_taken  = is_jump ? 1'b1 : ex_taken_i;
        act_tgt    = ex_target_i & ~XLEN'(1);
        redirect_o = ctl && ((act_taken != ex_pred_taken_i) ||
                             (act_taken && (act_tgt != ex_pred_target_i)));
        correct_pc = act_taken ? act_tgt : ex_pc_i + XLEN'(4);
    end

    // A redirect wins over stall so a resolved misprediction is never dropped.
    always_comb begin
        next_pc = F_pc_o + XLEN'(4);
        if (F_bubble_i)
            next_pc = RESET_PC;
        else if (redirect_o)
            next_pc = correct_pc;
        else if (F_stall_i)
            next_pc = F_pc_o;
        else if (f_pred_taken_o)
            next_pc = f_pred_target_o;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            F_pc_o        <= RESET_PC;
            mispred_cnt_o <= '0;
        end else begin
            F_pc_o <= next_pc;
            if (redirect_o && (mispred_cnt_o != '1))
                mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            btb_valid <= '0;
        else if (ctl && (e_hit || act_taken))
            btb_valid[e_idx] <= 1'b1;
    end

    // Payload arrays carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && ctl) begin
            if (e_hit) begin
                btb_jump[e_idx] <= is_jump;
                if (act_taken) begin
                    btb_target[e_idx] <= act_tgt;
                    if (btb_ctr[e_idx] != 2'b11)
                        btb_ctr[e_idx] <= btb_ctr[e_idx] + 2'd1;
                end else if (btb_ctr[e_idx] != 2'b00) begin
                    btb_ctr[e_idx] <= btb_ctr[e_idx] - 2'd1;
                end
            end else if (act_taken) begin
                btb_tag[e_idx]    <= e_tag;
                btb_target[e_idx] <= act_tgt;
                btb_jump[e_idx]   <= is_jump;
                btb_ctr[e_idx]    <= is_jump ? 2'b11 : 2'b10;
            end
        end
    end

endmodule
